// File: rtl/segment_capture_sequencer.sv
// segment_capture_sequencer
// Sequences multi-segment ADC captures around the trigger unit, all on adc_clk.
// Arms the trigger unit, counts samples per segment and drives the sample-FIFO
// write enable. Later segments start on a new trigger pulse or on a fixed
// start-to-start period. Completion, segment count and FIFO overflow are
// reported to the register block.
// Optional build macro: SEQ_TIMEOUT_EN adds trig_timeout_i / timeout_o and a
// trigger wait counter; without it the block waits for triggers indefinitely.
module segment_capture_sequencer #(
  parameter int SAMPLE_W = 20,
  parameter int SEG_W    = 16,
  parameter int CYC_W    = 20
) (
  input  logic                adc_clk,
  input  logic                reset_n,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                capture_go_i,
  input  logic                seg_timed_i,
  input  logic [SEG_W-1:0]    num_segments_i,
  input  logic [SAMPLE_W-1:0] segment_samples_i,
  input  logic [CYC_W-1:0]    segment_cycles_i,
  input  logic                fifo_full_i,
`ifdef SEQ_TIMEOUT_EN
  input  logic [31:0]         trig_timeout_i,
  output logic                timeout_o,
`endif
  output logic                trig_arm_o,
  output logic                sample_en_o,
  output logic                segment_start_o,
  output logic [SEG_W-1:0]    seg_count_o,
  output logic                capture_done_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic [2:0]          state_o
);

  localparam int CMP_W = (SAMPLE_W > CYC_W) ? SAMPLE_W : CYC_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Configuration captured when a sequence starts
  logic                r_timed;
  logic [SEG_W-1:0]    r_num_seg;
  logic [SAMPLE_W-1:0] r_seg_samples;
  logic [CYC_W-1:0]    r_seg_cycles;

  logic                r_arm_dly;
  logic [SAMPLE_W-1:0] r_samp_cnt;
  logic [CYC_W-1:0]    r_cyc_cnt;
  logic [SEG_W-1:0]    r_seg_count;
  logic                r_overflow;

  logic                w_arm_rise;
  logic                w_stop;
  logic                w_start_seq;
  logic                w_in_capture;
  logic                w_sample_ok;
  logic                w_overflow;
  logic                w_last_sample;
  logic                w_seg_done;
  logic                w_seq_done;
  logic                w_back_to_back;
  logic                w_period_hit;
  logic                w_start_seg;
  logic                w_timeout_hit;
  logic [SEG_W-1:0]    w_seg_count_inc;

  assign w_arm_rise      = arm_i & ~r_arm_dly;
  // Dropping arm and abort both end an active sequence; abort beats everything
  assign w_stop          = abort_i | ~arm_i;
  assign w_start_seq     = (r_state == ST_IDLE) & w_arm_rise & ~abort_i;
  assign w_in_capture    = (r_state == ST_CAPTURE);
  assign w_sample_ok     = w_in_capture & ~fifo_full_i & ~w_stop;
  // A full FIFO on a sample cycle wins over the last-sample bookkeeping
  assign w_overflow      = w_in_capture & fifo_full_i & ~w_stop;
  assign w_last_sample   = w_in_capture & (r_samp_cnt == r_seg_samples - SAMPLE_W'(1));
  assign w_seg_done      = w_last_sample & ~fifo_full_i & ~w_stop;
  assign w_seg_count_inc = r_seg_count + SEG_W'(1);
  assign w_seq_done      = w_seg_done & (w_seg_count_inc == r_num_seg);
  // Period no longer than a segment: next segment follows with no idle cycle
  assign w_back_to_back  = CMP_W'(r_seg_cycles) <= CMP_W'(r_seg_samples);
  // Next cycle's cyc_cnt would equal the period -> that cycle is the next first sample
  assign w_period_hit    = ({1'b0, r_cyc_cnt} + (CYC_W+1)'(1)) >= {1'b0, r_seg_cycles};
  assign w_start_seg     = (w_next_state == ST_CAPTURE) & (~w_in_capture | w_seg_done);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_seq) w_next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_stop)             w_next_state = ST_IDLE;
        else if (capture_go_i)  w_next_state = ST_CAPTURE;
        else if (w_timeout_hit) w_next_state = ST_DONE;
      end
      ST_CAPTURE: begin
        if (w_stop)                         w_next_state = ST_IDLE;
        else if (w_overflow)                w_next_state = ST_DONE;
        else if (w_seg_done) begin
          if (w_seq_done)                   w_next_state = ST_DONE;
          else if (r_timed & w_back_to_back) w_next_state = ST_CAPTURE;
          else                              w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_stop)                         w_next_state = ST_IDLE;
        else if (r_timed) begin
          if (w_period_hit)                 w_next_state = ST_CAPTURE;
        end
        else if (capture_go_i)              w_next_state = ST_CAPTURE;
        else if (w_timeout_hit)             w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (!arm_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the registered state and this cycle's qualifiers
  always_comb begin
    trig_arm_o      = (r_state == ST_ARMED) | (r_state == ST_CAPTURE) | (r_state == ST_GAP);
    sample_en_o     = w_sample_ok;
    segment_start_o = w_sample_ok & (r_samp_cnt == '0);
    capture_done_o  = (r_state == ST_DONE);
    busy_o          = (r_state != ST_IDLE);
    state_o         = r_state;
    seg_count_o     = r_seg_count;
    overflow_o      = r_overflow;
  end

  // Latch configuration and clear status on the arm rising edge
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_dly     <= 1'b0;
      r_timed       <= 1'b0;
      r_num_seg     <= '0;
      r_seg_samples <= '0;
      r_seg_cycles  <= '0;
      r_seg_count   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_arm_dly <= arm_i;
      if (w_start_seq) begin
        r_timed       <= seg_timed_i;
        r_num_seg     <= (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;
        r_seg_samples <= (segment_samples_i == '0) ? SAMPLE_W'(1) : segment_samples_i;
        r_seg_cycles  <= segment_cycles_i;
        r_seg_count   <= '0;
        r_overflow    <= 1'b0;
      end else begin
        if (w_seg_done) r_seg_count <= w_seg_count_inc;
        if (w_overflow) r_overflow  <= 1'b1;
      end
    end
  end

  // Sample counter within a segment and saturating start-to-start cycle counter
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_samp_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else if (w_start_seg) begin
      r_samp_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      if (w_in_capture) r_samp_cnt <= r_samp_cnt + SAMPLE_W'(1);
      if ((w_in_capture | (r_state == ST_GAP)) & ~(&r_cyc_cnt))
        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] r_timeout_lim;
  logic [31:0] r_wait_cnt;
  logic        r_timeout;
  logic        w_waiting;

  // Waiting for a trigger: ARMED, or GAP when segments are trigger-started
  assign w_waiting     = (r_state == ST_ARMED) | ((r_state == ST_GAP) & ~r_timed);
  assign w_timeout_hit = w_waiting & (r_timeout_lim != '0) & (r_wait_cnt == r_timeout_lim);
  assign timeout_o     = r_timeout;

  // Trigger wait counter and sticky timeout flag
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_lim <= '0;
      r_wait_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_start_seq) begin
        r_timeout_lim <= trig_timeout_i;
        r_timeout     <= 1'b0;
      end else if (w_timeout_hit & ~w_stop & ~capture_go_i) begin
        r_timeout <= 1'b1;
      end
      if (!w_waiting || capture_go_i) r_wait_cnt <= '0;
      else if (~(&r_wait_cnt))        r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_segment_capture_sequencer.sv
// Self-checking bench for segment_capture_sequencer.
// The reference model derives the expected sample / segment-start cycles of a
// whole sequence from the trigger times and configuration with plain
// arithmetic, then compares per cycle. Build with SEQ_TIMEOUT_EN to add the
// timeout checks.
module tb_segment_capture_sequencer;
  localparam int SAMPLE_W = 20;
  localparam int SEG_W    = 16;
  localparam int CYC_W    = 20;
  localparam int MAXT     = 256;

  logic                adc_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                arm_i = 1'b0;
  logic                abort_i = 1'b0;
  logic                capture_go_i = 1'b0;
  logic                seg_timed_i = 1'b0;
  logic [SEG_W-1:0]    num_segments_i = '0;
  logic [SAMPLE_W-1:0] segment_samples_i = '0;
  logic [CYC_W-1:0]    segment_cycles_i = '0;
  logic                fifo_full_i = 1'b0;
`ifdef SEQ_TIMEOUT_EN
  logic [31:0]         trig_timeout_i = '0;
  logic                timeout_o;
`endif
  logic                trig_arm_o;
  logic                sample_en_o;
  logic                segment_start_o;
  logic [SEG_W-1:0]    seg_count_o;
  logic                capture_done_o;
  logic                busy_o;
  logic                overflow_o;
  logic [2:0]          state_o;

  int n_checks = 0;
  int n_fail   = 0;

  segment_capture_sequencer #(
    .SAMPLE_W(SAMPLE_W), .SEG_W(SEG_W), .CYC_W(CYC_W)
  ) dut (
    .adc_clk          (adc_clk),
    .reset_n          (reset_n),
    .arm_i            (arm_i),
    .abort_i          (abort_i),
    .capture_go_i     (capture_go_i),
    .seg_timed_i      (seg_timed_i),
    .num_segments_i   (num_segments_i),
    .segment_samples_i(segment_samples_i),
    .segment_cycles_i (segment_cycles_i),
    .fifo_full_i      (fifo_full_i),
`ifdef SEQ_TIMEOUT_EN
    .trig_timeout_i   (trig_timeout_i),
    .timeout_o        (timeout_o),
`endif
    .trig_arm_o       (trig_arm_o),
    .sample_en_o      (sample_en_o),
    .segment_start_o  (segment_start_o),
    .seg_count_o      (seg_count_o),
    .capture_done_o   (capture_done_o),
    .busy_o           (busy_o),
    .overflow_o       (overflow_o),
    .state_o          (state_o)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_cfg(input int nseg, input int s, input int cyc, input bit timed);
    num_segments_i    = SEG_W'(nseg);
    segment_samples_i = SAMPLE_W'(s);
    segment_cycles_i  = CYC_W'(cyc);
    seg_timed_i       = timed;
  endtask

  task automatic scramble_cfg();
    num_segments_i    = SEG_W'($urandom);
    segment_samples_i = SAMPLE_W'($urandom);
    segment_cycles_i  = CYC_W'($urandom);
    seg_timed_i       = 1'($urandom);
  endtask

  // Drop arm and confirm the block returns to IDLE with done cleared
  task automatic release_arm(input string name);
    @(negedge adc_clk);
    arm_i = 1'b0; abort_i = 1'b0; capture_go_i = 1'b0; fifo_full_i = 1'b0;
    @(negedge adc_clk);
    #1;
    check({name, " idle state"}, 32'(state_o), 32'd0);
    check({name, " idle done"}, 32'(capture_done_o), 32'd0);
    check({name, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  // One full sequence. Cycle t=0 carries the arm rising edge; ARMED from t=1.
  // ovf_idx >= 0 puts fifo_full_i on that (0-based) sample of the sequence.
  task automatic run_seq(input int nseg_raw, input int s_raw, input int cyc, input bit timed,
                         input int first_go, input int spacing, input int ovf_idx,
                         input string name);
    int nseg, s, pitch, tf, end_t, exp_cnt;
    int starts[$];
    int samp_t[$];
    bit exp_samp [MAXT];
    bit exp_start[MAXT];
    bit go_at    [MAXT];
    bit full_at  [MAXT];
    for (int i = 0; i < MAXT; i++) begin
      exp_samp[i] = 0; exp_start[i] = 0; go_at[i] = 0; full_at[i] = 0;
    end
    nseg  = (nseg_raw == 0) ? 1 : nseg_raw;
    s     = (s_raw == 0) ? 1 : s_raw;
    pitch = (cyc <= s) ? s : cyc;
    for (int k = 0; k < nseg; k++) begin
      if (timed) begin
        starts.push_back(first_go + 1 + k * pitch);
      end else begin
        starts.push_back(first_go + k * spacing + 1);
        go_at[first_go + k * spacing] = 1;
      end
    end
    if (timed) go_at[first_go] = 1;
    foreach (starts[k]) for (int j = 0; j < s; j++) samp_t.push_back(starts[k] + j);
    tf    = (ovf_idx >= 0) ? samp_t[ovf_idx] : MAXT;
    end_t = (ovf_idx >= 0) ? tf : samp_t[samp_t.size() - 1];
    foreach (samp_t[i]) if (samp_t[i] < tf) exp_samp[samp_t[i]] = 1;
    foreach (starts[k]) if (starts[k] < tf) exp_start[starts[k]] = 1;
    if (ovf_idx >= 0) full_at[tf] = 1;
    // Noise that must have no effect: FIFO full off sample cycles, triggers
    // while capturing (or anywhere after the first trigger in timed mode)
    for (int t = 1; t <= end_t + 3; t++) begin
      if (!exp_samp[t] && t != tf && $urandom_range(3) == 0) full_at[t] = 1;
      if (t > first_go && !go_at[t] && $urandom_range(2) == 0 &&
          (timed || exp_samp[t] || t == tf)) go_at[t] = 1;
    end

    for (int t = 0; t <= end_t + 3; t++) begin
      @(negedge adc_clk);
      arm_i        = 1'b1;
      abort_i      = 1'b0;
      capture_go_i = go_at[t];
      fifo_full_i  = full_at[t];
      if (t == 0) begin
        set_cfg(nseg_raw, s_raw, cyc, timed);
`ifdef SEQ_TIMEOUT_EN
        trig_timeout_i = '0;
`endif
      end else begin
        scramble_cfg();
      end
      #1;
      check($sformatf("%s sample_en t=%0d", name, t), 32'(sample_en_o), 32'(exp_samp[t]));
      check($sformatf("%s seg_start t=%0d", name, t), 32'(segment_start_o), 32'(exp_start[t]));
      check($sformatf("%s trig_arm t=%0d", name, t), 32'(trig_arm_o),
            32'(t >= 1 && t <= end_t));
      check($sformatf("%s done t=%0d", name, t), 32'(capture_done_o), 32'(t > end_t));
      if (t >= 1) begin
        exp_cnt = 0;
        foreach (starts[k]) if (starts[k] + s - 1 < t && starts[k] + s - 1 < tf) exp_cnt++;
        check($sformatf("%s seg_count t=%0d", name, t), 32'(seg_count_o), 32'(exp_cnt));
        check($sformatf("%s overflow t=%0d", name, t), 32'(overflow_o),
              32'(ovf_idx >= 0 && t > tf));
      end
    end
    check({name, " final state"}, 32'(state_o), 32'd4);
    release_arm(name);
  endtask

  // arm dropped (use_abort=0) or abort pulsed (use_abort=1) mid-CAPTURE of segment 2
  task automatic run_stop(input bit use_abort, input string name);
    for (int t = 0; t <= 24; t++) begin
      @(negedge adc_clk);
      arm_i        = use_abort || t < 15;
      abort_i      = use_abort && t == 15;
      capture_go_i = (t == 2 || t == 12 || t == 17 || t == 20);
      fifo_full_i  = 1'b0;
      if (t == 0) set_cfg(3, 6, 0, 0);
      #1;
      if (t == 14) check({name, " sampling before stop"}, 32'(sample_en_o), 32'd1);
      if (t >= 16) begin
        check($sformatf("%s state t=%0d", name, t), 32'(state_o), 32'd0);
        check($sformatf("%s sample_en t=%0d", name, t), 32'(sample_en_o), 32'd0);
        check($sformatf("%s trig_arm t=%0d", name, t), 32'(trig_arm_o), 32'd0);
        check($sformatf("%s done t=%0d", name, t), 32'(capture_done_o), 32'd0);
        check($sformatf("%s seg_count t=%0d", name, t), 32'(seg_count_o), 32'd1);
      end
    end
    release_arm(name);
  endtask

  // Trigger and abort in the same ARMED cycle: abort wins
  task automatic run_go_abort();
    for (int t = 0; t <= 4; t++) begin
      @(negedge adc_clk);
      arm_i        = 1'b1;
      capture_go_i = (t == 2);
      abort_i      = (t == 2);
      if (t == 0) set_cfg(2, 3, 0, 0);
      #1;
      if (t >= 3) begin
        check($sformatf("go_abort state t=%0d", t), 32'(state_o), 32'd0);
        check($sformatf("go_abort sample_en t=%0d", t), 32'(sample_en_o), 32'd0);
      end
    end
    release_arm("go_abort");
  endtask

  // Reset asserted while waiting in GAP: outputs clear without a clock edge
  task automatic run_reset_gap();
    for (int t = 0; t <= 6; t++) begin
      @(negedge adc_clk);
      arm_i        = 1'b1;
      capture_go_i = (t == 2);
      if (t == 0) set_cfg(3, 2, 0, 0);
      #1;
    end
    check("rst_gap state before", 32'(state_o), 32'd3);
    check("rst_gap seg_count before", 32'(seg_count_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_gap state", 32'(state_o), 32'd0);
    check("rst_gap trig_arm", 32'(trig_arm_o), 32'd0);
    check("rst_gap busy", 32'(busy_o), 32'd0);
    check("rst_gap seg_count", 32'(seg_count_o), 32'd0);
    check("rst_gap done", 32'(capture_done_o), 32'd0);
    check("rst_gap sample_en", 32'(sample_en_o), 32'd0);
    @(negedge adc_clk);
    arm_i = 1'b0; capture_go_i = 1'b0;
    reset_n = 1'b1;
    @(negedge adc_clk);
  endtask

`ifdef SEQ_TIMEOUT_EN
  // No triggers: with a limit the wait counter hits it; without, stay ARMED
  task automatic run_timeout(input int lim, input int ncyc, input string name);
    for (int t = 0; t <= ncyc; t++) begin
      @(negedge adc_clk);
      arm_i = 1'b1; capture_go_i = 1'b0; fifo_full_i = 1'b0;
      if (t == 0) begin set_cfg(2, 3, 0, 0); trig_timeout_i = 32'(lim); end
      #1;
      if (lim != 0 && t >= 1) begin
        check($sformatf("%s timeout t=%0d", name, t), 32'(timeout_o), 32'(t >= lim + 2));
        check($sformatf("%s done t=%0d", name, t), 32'(capture_done_o), 32'(t >= lim + 2));
      end
    end
    if (lim == 0) begin
      check({name, " still armed"}, 32'(state_o), 32'd1);
      check({name, " no timeout"}, 32'(timeout_o), 32'd0);
    end
    trig_timeout_i = '0;
    release_arm(name);
  endtask
`endif

  initial begin
    int nseg_r, s_r, s_eff, nseg_eff, ovf;
    bit tm;
    #1;
    check("reset state", 32'(state_o), 32'd0);
    check("reset trig_arm", 32'(trig_arm_o), 32'd0);
    check("reset sample_en", 32'(sample_en_o), 32'd0);
    check("reset seg_start", 32'(segment_start_o), 32'd0);
    check("reset seg_count", 32'(seg_count_o), 32'd0);
    check("reset done", 32'(capture_done_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset overflow", 32'(overflow_o), 32'd0);
    repeat (2) @(negedge adc_clk);
    reset_n = 1'b1;
    @(negedge adc_clk);

    run_seq(3, 4, 0, 0, 2, 20, -1, "trig3x4");
    run_seq(4, 5, 8, 1, 3, 0, -1, "timed4x5p8");
    run_seq(2, 6, 3, 1, 2, 0, -1, "b2b2x6p3");
    run_seq(3, 4, 0, 0, 2, 10, 6, "ovf_seg2");
    run_seq(1, 3, 0, 0, 1, 10, -1, "ovf_cleared");
    run_seq(0, 0, 0, 1, 1, 0, -1, "zero_cfg");
    run_seq(3, 2, 3, 1, 4, 0, -1, "timed_gap1");
    run_stop(1'b0, "arm_drop");
    run_stop(1'b1, "abort");
    run_go_abort();
    run_reset_gap();

    for (int i = 0; i < 40; i++) begin
      nseg_r   = $urandom_range(0, 4);
      s_r      = $urandom_range(0, 6);
      tm       = 1'($urandom);
      s_eff    = (s_r == 0) ? 1 : s_r;
      nseg_eff = (nseg_r == 0) ? 1 : nseg_r;
      ovf      = ($urandom_range(3) == 0) ? $urandom_range(0, nseg_eff * s_eff - 1) : -1;
      run_seq(nseg_r, s_r, $urandom_range(0, 10), tm, $urandom_range(1, 5),
              s_eff + 1 + $urandom_range(0, 4), ovf, $sformatf("rand%0d", i));
    end

`ifdef SEQ_TIMEOUT_EN
    run_timeout(50, 60, "timeout50");
    run_timeout(0, 1000, "timeout_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
